uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 91 +++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and transmit FSM state encoding
package uart_pkg;

  localparam int CLK_HZ     = 27_000_000;
  localparam int BAUD       = 115_200;
  localparam int BIT_DIV    = 234;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - byte FIFO storage with count-based full/empty and overflow pulse
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_nonempty_next
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_next;

  // Full is the registered flag, so a pop in the same cycle never rescues a push.
  assign w_push       = i_wr_en & ~r_full & ~i_rst;
  assign w_pop        = i_rd_en & ~r_empty & ~i_rst;
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign o_rd_data       = r_mem[r_rd_ptr];
  assign o_full          = r_full;
  assign o_empty         = r_empty;
  assign o_count         = r_count;
  assign o_overflow      = r_overflow;
  assign o_nonempty_next = (w_count_next != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == (AW+1)'(DEPTH));
      r_empty    <= (w_count_next == '0);
      r_overflow <= i_wr_en & r_full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through a strobe/busy handshake
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_we,
  input  logic          i_tx_busy,
  output logic          o_active
);

  tx_state_t  r_state;
  logic       r_active;
  logic [7:0] w_rd_data;
  logic       w_nonempty_next;
  logic       w_pop;

  assign w_pop    = (r_state == ST_IDLE) & ~o_empty & ~i_tx_busy;
  assign o_active = r_active;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_wr_data       (i_wr_data),
    .i_wr_en         (i_wr_en),
    .i_rd_en         (w_pop),
    .o_rd_data       (w_rd_data),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_count         (o_count),
    .o_overflow      (o_overflow),
    .o_nonempty_next (w_nonempty_next)
  );

  // SETTLE covers the cycle before the transmitter raises busy, so busy is not trusted there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      o_tx_we   <= 1'b0;
      o_tx_data <= 8'h00;
      r_active  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state   <= ST_SETTLE;
            o_tx_data <= w_rd_data;
            o_tx_we   <= 1'b1;
            r_active  <= 1'b1;
          end else begin
            o_tx_we   <= 1'b0;
            r_active  <= w_nonempty_next;
          end
        end
        ST_SETTLE: begin
          r_state  <= ST_DRAIN;
          o_tx_we  <= 1'b0;
          r_active <= 1'b1;
        end
        ST_DRAIN: begin
          o_tx_we <= 1'b0;
          if (!i_tx_busy) begin
            r_state  <= ST_IDLE;
            r_active <= w_nonempty_next;
          end else begin
            r_active <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          o_tx_we  <= 1'b0;
          r_active <= w_nonempty_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized and directed checks of uart_tx_fifo against a queue model
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_wr_data = 8'h00;
  logic          i_wr_en = 1'b0;
  logic          o_full, o_empty, o_overflow, o_tx_we, o_active;
  logic [AW:0]   o_count;
  logic [7:0]    o_tx_data;
  logic          i_tx_busy;

  always #5 i_clk = ~i_clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_data  (i_wr_data),
    .i_wr_en    (i_wr_en),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_tx_data  (o_tx_data),
    .o_tx_we    (o_tx_we),
    .i_tx_busy  (i_tx_busy),
    .o_active   (o_active)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy rises the cycle after a strobe and lasts one 10-bit frame.
  int         bit_clks  = 3;
  logic       hold_busy = 1'b0;
  logic       t_busy    = 1'b0;
  logic [9:0] t_frame   = 10'h3ff;
  logic [3:0] t_bit     = 4'd0;
  int         t_cnt     = 0;
  logic       tx_line;

  assign i_tx_busy = t_busy | hold_busy;
  assign tx_line   = t_busy ? t_frame[t_bit] : 1'b1;

  always @(posedge i_clk) begin
    if (!t_busy) begin
      if (o_tx_we) begin
        t_busy  <= 1'b1;
        t_frame <= {1'b1, o_tx_data, 1'b0};
        t_bit   <= 4'd0;
        t_cnt   <= 0;
      end
    end else if (t_cnt == bit_clks - 1) begin
      t_cnt <= 0;
      if (t_bit == 4'd9) t_busy <= 1'b0;
      else               t_bit  <= t_bit + 4'd1;
    end else begin
      t_cnt <= t_cnt + 1;
    end
  end

  // Reference model: accepted bytes queue in order; occupancy = accepted - transmitted.
  logic [7:0] exp_q[$];
  int   m_acc = 0, m_str = 0, str_seen = 0, ovf_seen = 0;
  logic exp_ovf = 1'b0;
  logic full_m;

  initial begin
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        m_acc = 0; m_str = 0; exp_ovf = 1'b0;
        exp_q.delete();
      end else begin
        full_m  = ((m_acc - m_str) == DEPTH);
        exp_ovf = i_wr_en && full_m;
        if (i_wr_en && !full_m) begin
          exp_q.push_back(i_wr_data);
          m_acc++;
        end
      end
      #1;
      if (o_tx_we) begin
        str_seen++;
        check("strobe_busy", 32'(i_tx_busy), 32'd0);
        if (exp_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else                   check("strobe_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
        m_str++;
      end
      if (o_overflow) ovf_seen++;
      check("count",    32'(o_count),    32'(m_acc - m_str));
      check("full",     32'(o_full),     32'((m_acc - m_str) == DEPTH));
      check("empty",    32'(o_empty),    32'((m_acc - m_str) == 0));
      check("overflow", 32'(o_overflow), 32'(exp_ovf));
      if ((m_acc - m_str) != 0 || o_tx_we) check("active", 32'(o_active), 32'd1);
    end
  end

  task automatic push(input logic [7:0] b);
    i_wr_en   = 1'b1;
    i_wr_data = b;
    @(negedge i_clk);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((exp_q.size() != 0 || o_active || i_tx_busy) && k < limit) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= limit) check("idle_timeout", 32'd1, 32'd0);
    @(negedge i_clk);
    check("idle_active", 32'(o_active), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, o0, k, low_len;
    logic [9:0] rx;

    repeat (3) @(negedge i_clk);
    check("rst_empty",  32'(o_empty),   32'd1);
    check("rst_full",   32'(o_full),    32'd0);
    check("rst_active", 32'(o_active),  32'd0);
    check("rst_we",     32'(o_tx_we),   32'd0);
    check("rst_data",   32'(o_tx_data), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single byte at full baud divisor: strobe two cycles after the push, then a serial frame.
    bit_clks = BIT_DIV;
    push(8'h55);
    i_wr_en = 1'b0;
    check("lat_we_t1", 32'(o_tx_we), 32'd0);
    @(negedge i_clk);
    check("lat_we_t2",   32'(o_tx_we),   32'd1);
    check("lat_data_t2", 32'(o_tx_data), 32'h55);
    k = 0;
    while (tx_line && k < 20) begin @(negedge i_clk); k++; end
    low_len = 0;
    while (!tx_line && low_len < 1000) begin @(negedge i_clk); low_len++; end
    check("start_bit_len", 32'(low_len), 32'(BIT_DIV));
    rx = '0;
    for (int i = 1; i < 10; i++) begin
      repeat ((i == 1) ? (BIT_DIV / 2 - 1) : BIT_DIV) @(negedge i_clk);
      rx[i] = tx_line;
    end
    check("serial_data", 32'(rx[8:1]), 32'h55);
    check("serial_stop", 32'(rx[9]),   32'd1);
    wait_idle(3000);

    // Burst of three.
    bit_clks = 3;
    s0 = str_seen;
    push(8'h41); push(8'h42); push(8'h43);
    i_wr_en = 1'b0;
    wait_idle(500);
    check("burst_strobes", 32'(str_seen - s0), 32'd3);

    // Fill with transmitter held busy; the 17th push is dropped.
    hold_busy = 1'b1;
    @(negedge i_clk);
    o0 = ovf_seen;
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    i_wr_en = 1'b0;
    check("ovf_pulses", 32'(ovf_seen - o0), 32'd1);
    check("full_count", 32'(o_count), 32'd16);
    check("full_flag",  32'(o_full),  32'd1);

    // Push during the pop cycle while full: dropped, count drops to 15.
    hold_busy = 1'b0;
    i_wr_en   = 1'b1;
    i_wr_data = 8'hAA;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    check("simul_count", 32'(o_count),    32'd15);
    check("simul_ovf",   32'(o_overflow), 32'd1);
    wait_idle(2000);

    // Forty bytes through the ring, throttled to avoid overflow.
    s0 = str_seen;
    for (int i = 0; i < 40; i++) begin
      i_wr_en = 1'b0;
      while ((m_acc - m_str) >= DEPTH - 1) @(negedge i_clk);
      push(8'(i));
    end
    i_wr_en = 1'b0;
    wait_idle(3000);
    check("wrap_strobes", 32'(str_seen - s0), 32'd40);

    // Reset while draining with five bytes queued.
    for (int i = 0; i < 6; i++) push(8'h70 + 8'(i));
    i_wr_en = 1'b0;
    @(negedge i_clk);
    check("pre_rst_count", 32'(o_count),   32'd5);
    check("pre_rst_busy",  32'(i_tx_busy), 32'd1);
    i_rst     = 1'b1;
    i_wr_en   = 1'b1;
    i_wr_data = 8'hEE;
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_wr_en = 1'b0;
    check("mid_rst_empty",  32'(o_empty),  32'd1);
    check("mid_rst_we",     32'(o_tx_we),  32'd0);
    check("mid_rst_active", 32'(o_active), 32'd0);
    s0 = str_seen;
    repeat (100) @(negedge i_clk);
    check("mid_rst_strobes", 32'(str_seen - s0), 32'd0);

    // Random traffic with random busy stalls and frame lengths.
    for (int r = 0; r < 4; r++) begin
      bit_clks = $urandom_range(1, 4);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 15) == 0) hold_busy = ~hold_busy;
        i_wr_en   = ($urandom_range(0, 2) != 0);
        i_wr_data = 8'($urandom);
        @(negedge i_clk);
      end
      i_wr_en   = 1'b0;
      hold_busy = 1'b0;
      wait_idle(5000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
